// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: WB stage vs. out-of-band late results.
// Tracks pending late writes and kills late data made stale by a pipeline WAW.
module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pipe_we,
  input  logic [ADDR_W-1:0]      pipe_addr,
  input  logic [DATA_W-1:0]      pipe_wdata,
  input  logic                   lt_issue,
  input  logic [ADDR_W-1:0]      lt_issue_addr,
  input  logic                   lt_valid,
  input  logic [ADDR_W-1:0]      lt_addr,
  input  logic [DATA_W-1:0]      lt_wdata,
  output logic                   lt_ready,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_addr,
  output logic [DATA_W-1:0]      rf_wdata,
  output logic [(1<<ADDR_W)-1:0] busy_mask,
  output logic                   stall_req
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);

  logic              r_hold_valid;
  logic [ADDR_W-1:0] r_hold_addr;
  logic [DATA_W-1:0] r_hold_data;
  logic              r_hold_kill;
  logic [NREG-1:0]   r_busy;
  logic [NREG-1:0]   r_kill;
  logic [3:0]        r_starve;
  logic              r_stall;
  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_addr;
  logic [DATA_W-1:0] r_rf_wdata;

  logic            w_xfer;
  logic            w_hold_win;
  logic            w_pipe_win;
  logic            w_waw;
  logic [NREG-1:0] w_busy;
  logic [NREG-1:0] w_kill;

  always_comb begin
    w_xfer     = lt_valid && !r_hold_valid;
    w_hold_win = r_hold_valid && (r_stall || !pipe_we);
    w_pipe_win = pipe_we && !r_stall;
    w_waw      = w_pipe_win && (pipe_addr != '0) && r_busy[pipe_addr];
    w_busy     = r_busy;
    w_kill     = r_kill;
    if (w_waw) begin
      w_busy[pipe_addr] = 1'b0;
      w_kill[pipe_addr] = 1'b1;
    end
    // late arrival retires its kill bit; a fresh issue re-arms busy
    if (w_xfer) begin
      w_busy[lt_addr] = 1'b0;
      w_kill[lt_addr] = 1'b0;
    end
    if (lt_issue && (lt_issue_addr != '0))
      w_busy[lt_issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold_addr  <= '0;
      r_hold_data  <= '0;
      r_hold_kill  <= 1'b0;
      r_busy       <= '0;
      r_kill       <= '0;
      r_starve     <= '0;
      r_stall      <= 1'b0;
      r_rf_we      <= 1'b0;
      r_rf_addr    <= '0;
      r_rf_wdata   <= '0;
    end else begin
      r_busy <= w_busy;
      r_kill <= w_kill;

      if (w_hold_win) begin
        r_hold_valid <= 1'b0;
      end else if (w_xfer) begin
        r_hold_valid <= 1'b1;
        r_hold_addr  <= lt_addr;
        r_hold_data  <= lt_wdata;
        r_hold_kill  <= r_kill[lt_addr];
      end

      if (w_hold_win) begin
        r_rf_we    <= (r_hold_addr != '0) && !r_hold_kill;
        r_rf_addr  <= r_hold_addr;
        r_rf_wdata <= r_hold_data;
      end else if (w_pipe_win) begin
        r_rf_we    <= (pipe_addr != '0);
        r_rf_addr  <= pipe_addr;
        r_rf_wdata <= pipe_wdata;
      end else begin
        r_rf_we    <= 1'b0;
      end

      // the stall cycle lets hold win, so stall can never repeat back-to-back
      if (r_hold_valid && w_pipe_win) begin
        if (r_starve == STARVE_LAST) begin
          r_stall  <= 1'b1;
          r_starve <= '0;
        end else begin
          r_stall  <= 1'b0;
          r_starve <= r_starve + 4'd1;
        end
      end else begin
        r_stall  <= 1'b0;
        r_starve <= '0;
      end
    end
  end

  assign lt_ready  = !r_hold_valid;
  assign rf_we     = r_rf_we;
  assign rf_addr   = r_rf_addr;
  assign rf_wdata  = r_rf_wdata;
  assign busy_mask = r_busy;
  assign stall_req = r_stall;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: expected RF writes are queued
// as stimulus is driven and popped when rf_we is observed.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_wdata;
  logic        lt_issue;
  logic [4:0]  lt_issue_addr;
  logic        lt_valid;
  logic [4:0]  lt_addr;
  logic [31:0] lt_wdata;
  logic        lt_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_mask;
  logic        stall_req;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t q[$];
  int  n_run  = 0;
  int  n_fail = 0;
  int  d;

  wb_port_arbiter #(
    .DATA_W(32), .ADDR_W(5), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
    .lt_issue(lt_issue), .lt_issue_addr(lt_issue_addr),
    .lt_valid(lt_valid), .lt_addr(lt_addr), .lt_wdata(lt_wdata),
    .lt_ready(lt_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .busy_mask(busy_mask), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] dd);
    q.push_back(wr_t'{a, dd});
  endtask

  task automatic idle();
    pipe_we = 0; pipe_addr = 0; pipe_wdata = 0;
    lt_issue = 0; lt_issue_addr = 0;
    lt_valid = 0; lt_addr = 0; lt_wdata = 0;
  endtask

  task automatic issue(input logic [4:0] a);
    lt_issue = 1; lt_issue_addr = a;
    tick();
    lt_issue = 0;
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (rst_n && rf_we) begin
      if (q.size() == 0) begin
        chk("unexp_wr", {27'd0, rf_addr, rf_wdata}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("wr", {27'd0, rf_addr, rf_wdata}, {27'd0, e.a, e.d});
      end
    end
  end

  initial begin
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", rf_we, 0);
    chk("rst_addr", rf_addr, 0);
    chk("rst_data", rf_wdata, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_rdy", lt_ready, 1);
    rst_n = 1;
    tick();

    // idle late write
    issue(5'd8);
    chk("idle_busy1", busy_mask[8], 1);
    tick();
    chk("idle_busy2", busy_mask[8], 1);
    lt_valid = 1; lt_addr = 8; lt_wdata = 32'hDEADBEEF;
    chk("idle_rdy0", lt_ready, 1);
    push(5'd8, 32'hDEADBEEF);
    tick();
    lt_valid = 0;
    chk("idle_rdy1", lt_ready, 0);
    chk("idle_busy3", busy_mask[8], 0);
    chk("idle_we0", rf_we, 0);
    tick();
    chk("idle_rdy2", lt_ready, 1);
    chk("idle_we1", rf_we, 1);
    tick();
    chk("idle_we2", rf_we, 0);

    // reset while hold buffer is full
    issue(5'd5);
    lt_valid = 1; lt_addr = 5; lt_wdata = 32'h55;
    tick();
    lt_valid = 0;
    chk("mrst_rdy0", lt_ready, 0);
    rst_n = 0;
    #1;
    chk("mrst_rdy1", lt_ready, 1);
    chk("mrst_busy", busy_mask, 0);
    chk("mrst_we", rf_we, 0);
    tick();
    rst_n = 1;
    tick();
    tick();
    chk("mrst_we2", rf_we, 0);
    chk("mrst_rdy2", lt_ready, 1);

    // starvation: hold r3 vs continuous r9 writes
    issue(5'd3);
    lt_valid = 1; lt_addr = 3; lt_wdata = 32'h33;
    pipe_we = 1; pipe_addr = 9;
    d = 0;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("stv_stall%0d", i), stall_req, (i == 5));
      chk($sformatf("stv_rdy%0d", i), lt_ready, (i == 0 || i >= 6));
      pipe_wdata = 32'h900 + d;
      if (i == 5) begin
        push(5'd3, 32'h33);
      end else begin
        push(5'd9, 32'h900 + d);
        d++;
      end
      tick();
      lt_valid = 0;
    end
    chk("stv_busy", busy_mask[3], 0);
    idle();
    tick();
    tick();

    // WAW kill
    issue(5'd12);
    pipe_we = 1; pipe_addr = 12; pipe_wdata = 32'h11;
    push(5'd12, 32'h11);
    tick();
    pipe_we = 0;
    chk("waw_busy", busy_mask[12], 0);
    lt_valid = 1; lt_addr = 12; lt_wdata = 32'h22;
    chk("waw_rdy0", lt_ready, 1);
    tick();
    lt_valid = 0;
    chk("waw_rdy1", lt_ready, 0);
    tick();
    chk("waw_we", rf_we, 0);
    chk("waw_rdy2", lt_ready, 1);
    tick();

    // kill bit retired: next late r12 writes
    issue(5'd12);
    lt_valid = 1; lt_addr = 12; lt_wdata = 32'h77;
    push(5'd12, 32'h77);
    tick();
    lt_valid = 0;
    tick();
    chk("rearm_we", rf_we, 1);
    tick();

    // $0 filtering
    pipe_we = 1; pipe_addr = 0; pipe_wdata = 32'hFFFFFFFF;
    lt_issue = 1; lt_issue_addr = 0;
    tick();
    idle();
    chk("r0_we", rf_we, 0);
    chk("r0_busy", busy_mask[0], 0);
    lt_valid = 1; lt_addr = 0; lt_wdata = 32'hABCD;
    tick();
    lt_valid = 0;
    tick();
    chk("r0_late_we", rf_we, 0);
    chk("r0_rdy", lt_ready, 1);

    // back-to-back late r4, r5
    issue(5'd4);
    issue(5'd5);
    chk("b2b_busy0", busy_mask[5:4], 2'b11);
    lt_valid = 1; lt_addr = 4; lt_wdata = 32'h44;
    push(5'd4, 32'h44);
    chk("b2b_rdy0", lt_ready, 1);
    tick();
    lt_addr = 5; lt_wdata = 32'h45;
    push(5'd5, 32'h45);
    chk("b2b_rdy1", lt_ready, 0);
    chk("b2b_busy1", busy_mask[5:4], 2'b10);
    tick();
    chk("b2b_rdy2", lt_ready, 1);
    chk("b2b_wr4", {rf_we, rf_addr}, {1'b1, 5'd4});
    tick();
    lt_valid = 0;
    chk("b2b_rdy3", lt_ready, 0);
    chk("b2b_busy2", busy_mask[5:4], 2'b00);
    tick();
    chk("b2b_wr5", {rf_we, rf_addr}, {1'b1, 5'd5});
    tick();

    // transfer and WAW on r6 in one cycle: both writes land, pipe first
    issue(5'd6);
    pipe_we = 1; pipe_addr = 6; pipe_wdata = 32'h60;
    lt_valid = 1; lt_addr = 6; lt_wdata = 32'h66;
    push(5'd6, 32'h60);
    push(5'd6, 32'h66);
    tick();
    idle();
    chk("same_busy", busy_mask[6], 0);
    tick();
    tick();

    // issue and transfer on r10 in one cycle: set wins
    issue(5'd10);
    lt_issue = 1; lt_issue_addr = 10;
    lt_valid = 1; lt_addr = 10; lt_wdata = 32'hA0;
    push(5'd10, 32'hA0);
    tick();
    idle();
    chk("setwin_busy", busy_mask[10], 1);
    tick();
    lt_valid = 1; lt_addr = 10; lt_wdata = 32'hA1;
    push(5'd10, 32'hA1);
    tick();
    lt_valid = 0;
    chk("setwin_clr", busy_mask[10], 0);
    repeat (3) tick();

    chk("sb_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources:
  - the in-order pipeline WB stage, which has priority;
  - a late-result source (bus loads returning out of band), which uses a valid/ready handshake.
- Keeps a 32-entry pending-write scoreboard so the hazard unit can stall on registers awaiting late data.
- Raises a one-cycle pipeline stall request when the late source has been starved too long.
- Sits between the WB mux (Mem2Reg/RegDst-selected data and address) and the GPR file.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width (the scoreboard has 2**ADDR_W bits).
- STARVE_MAX, 4, number of consecutive cycles a held late result may lose arbitration before stall_req fires (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pipe_we  in  1  WB stage write enable.
- pipe_addr  in  ADDR_W  WB destination register.
- pipe_wdata  in  DATA_W  WB write data.
- lt_issue  in  1  a late load was issued this cycle (from MEM stage).
- lt_issue_addr  in  ADDR_W  destination register of the issued late load.
- lt_valid  in  1  late result available.
- lt_addr  in  ADDR_W  late result destination register.
- lt_wdata  in  DATA_W  late result data.
- lt_ready  out  1  arbiter accepts the late result this cycle.
- rf_we  out  1  register-file write enable (registered).
- rf_addr  out  ADDR_W  register-file write address (registered).
- rf_wdata  out  DATA_W  register-file write data (registered).
- busy_mask  out  2**ADDR_W  scoreboard: bit n set means register n awaits a late write.
- stall_req  out  1  freeze the pipeline for this cycle (registered).

Behaviour:
- Reset (async, rst_n=0): rf_we=0, rf_addr=0, rf_wdata=0, busy_mask=0, stall_req=0, hold buffer empty, kill bits=0, starve counter=0. Asserting reset mid-transfer drops any held late result.
- Hold buffer:
  - One entry holding addr, data and a kill flag. lt_ready = !hold_valid, combinational from registered state.
  - A transfer occurs when lt_valid && lt_ready. It loads the hold buffer; kill = kill_bit[lt_addr]. The same edge clears busy_mask[lt_addr] and kill_bit[lt_addr].
- Port arbitration, evaluated each cycle; the result is registered onto rf_* (latency 1 cycle):
  - stall_req=1: hold wins. pipe_we is ignored because the pipeline re-presents the same write next cycle.
  - Otherwise, pipe_we=1: the pipeline wins.
  - Otherwise, hold_valid=1: hold wins.
  - Otherwise: rf_we=0.
  - When hold wins, the buffer empties on that edge, and lt_ready is 1 the following cycle.
  - rf_we = winner_we && addr!=0 && !(hold won && kill). Writes to $0 never drive rf_we=1. rf_addr/rf_wdata still update to the winner's values.
- Starvation:
  - The counter increments each cycle hold_valid=1 and the pipeline wins. It clears when hold wins or hold is empty.
  - When counter == STARVE_MAX-1 and the pipeline wins again, stall_req=1 on the next cycle, for exactly one cycle, and hold drains in that cycle. The counter then clears.
  - stall_req is never asserted on two consecutive cycles.
- Scoreboard:
  - lt_issue sets busy_mask[lt_issue_addr], except that address 0 is never set.
  - An issue to an already-busy address is illegal; the hazard unit prevents it, and the block need not handle it.
- WAW:
  - A pipeline write (pipe_we, addr!=0, pipeline wins) to a busy address clears busy_mask[addr] and sets kill_bit[addr].
  - The later late result for that address is accepted normally (lt_ready handshake completes) but does not write the register file.
- Simultaneous events, same address, same cycle:
  - Set (lt_issue) takes precedence over clear (late transfer or pipeline WAW).
  - A late transfer and a pipeline WAW in the same cycle: the transfer captures the old kill bit, so the data is written. It is ordered after the pipeline write.
- busy_mask and stall_req are registered outputs; no output depends combinationally on any input except lt_ready (which is state only).

Test Plan:
- Reset mid-hold: hold valid with addr 5, then rst_n low for 1 cycle → rf_we=0, lt_ready=1, busy_mask=0 after release; no write to r5 ever appears.
- Idle late write: lt_issue r8; two cycles later lt_valid r8/0xDEADBEEF with pipe_we=0 → busy_mask[8]=1 until the transfer edge; rf_we=1, rf_addr=8, rf_wdata=0xDEADBEEF one cycle after hold load; lt_ready low for exactly 1 cycle.
- Starvation with STARVE_MAX=4: hold valid r3, pipe_we=1 continuously to r9 → stall_req=1 on cycle 5 only; that cycle rf_addr=3; the r9 write resumes the next cycle; lt_ready rises after the drain.
- WAW kill: lt_issue r12, pipeline writes r12=0x11, then late result r12=0x22 → r12 written once with 0x11; late handshake completes with rf_we=0; busy_mask[12]=0 after the pipeline write.
- $0 filtering: pipe_we=1 addr 0 data 0xFFFFFFFF; lt_issue to r0 → rf_we stays 0; busy_mask[0] stays 0.
- Back-to-back late results r4, r5 with the pipeline idle → writes r4 then r5 on consecutive-but-one cycles; lt_ready pattern 1,0,1,0; busy bits clear in order.
